// File: rtl/lsb_param.sv
// lsb_param: parametrised in-order load/store buffer.
// Sits between dispatch, the CDBs, the ROB and the memory controller.
// Each entry snoops N_CDB result buses plus its own result output. Entries
// compute their effective address as soon as the base operand is ready. Only
// the head entry talks to memory. Loads are sign/zero-extended internally.
// Stores are reported once, then written after the ROB commits them.
// Optional feature macro: LSB_MISALIGN_EN. When defined, a misaligned head
// access is turned into an exception report and never reaches memory.
// Ports:
//   clk, rst (sync, active-low), rdy (global enable), in_flush
//   in_disp_*       dispatch request and operands
//   out_full/count  occupancy status (out_full is combinational)
//   in_cdb_*        packed external result buses (lowest index wins)
//   in_commit_*     ROB store commit
//   out_mem_*/in_mem_*   memory request/response
//   out_cdb_*       result broadcast (tag 0 = idle)
module lsb_param #(
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned ROB_TAG_W = 4,
   parameter int unsigned XLEN      = 32,
   parameter int unsigned N_CDB     = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       rdy,
   input  logic                       in_flush,
   input  logic                       in_disp_valid,
   input  logic [ROB_TAG_W-1:0]       in_disp_rob_tag,
   input  logic                       in_disp_is_store,
   input  logic [1:0]                 in_disp_size,
   input  logic                       in_disp_signed,
   input  logic [XLEN-1:0]            in_disp_v1,
   input  logic [XLEN-1:0]            in_disp_v2,
   input  logic [ROB_TAG_W-1:0]       in_disp_q1,
   input  logic [ROB_TAG_W-1:0]       in_disp_q2,
   input  logic [XLEN-1:0]            in_disp_imm,
   output logic                       out_full,
   output logic [$clog2(DEPTH):0]     out_count,
   input  logic [N_CDB*ROB_TAG_W-1:0] in_cdb_tag,
   input  logic [N_CDB*XLEN-1:0]      in_cdb_value,
   input  logic                       in_commit_valid,
   input  logic [ROB_TAG_W-1:0]       in_commit_tag,
   output logic                       out_mem_ce,
   output logic                       out_mem_we,
   output logic [1:0]                 out_mem_size,
   output logic [XLEN-1:0]            out_mem_addr,
   output logic [XLEN-1:0]            out_mem_wdata,
   input  logic                       in_mem_done,
   input  logic [XLEN-1:0]            in_mem_data,
   output logic [ROB_TAG_W-1:0]       out_cdb_tag,
   output logic [XLEN-1:0]            out_cdb_value,
   output logic [XLEN-1:0]            out_cdb_addr,
   output logic                       out_cdb_exc
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD_WAIT = 2'd1, S_STORE_WAIT = 2'd2} state_t;

   typedef struct packed {
      logic [ROB_TAG_W-1:0] q;
      logic [XLEN-1:0]      v;
   } opnd_t;

   typedef struct packed {
      logic                 valid;
      logic                 is_store;
      logic [1:0]           size;
      logic                 sgn;
      logic                 addr_ok;
      logic                 reported;
      logic [ROB_TAG_W-1:0] tag;
      opnd_t                op1;
      opnd_t                op2;
      logic [XLEN-1:0]      imm;
      logic [XLEN-1:0]      addr;
   } entry_t;

   state_t               r_state, w_state;
   entry_t               r_ent [DEPTH];
   entry_t               w_ent [DEPTH];
   logic [PW-1:0]        r_head, w_head, r_tail, w_tail;
   logic [CW-1:0]        r_count, w_count;
   logic                 r_mem_ce, w_mem_ce, r_mem_we, w_mem_we;
   logic [1:0]           r_mem_size, w_mem_size;
   logic [XLEN-1:0]      r_mem_addr, w_mem_addr, r_mem_wdata, w_mem_wdata;
   logic [ROB_TAG_W-1:0] r_cdb_tag, w_cdb_tag;
   logic [XLEN-1:0]      r_cdb_value, w_cdb_value, r_cdb_addr, w_cdb_addr;
   logic                 r_cdb_exc, w_cdb_exc;
   logic                 w_pop, w_push, w_full, w_mis;

   // Resolve a pending operand against the CDBs, then against our own result.
   function automatic opnd_t snoop(input opnd_t o,
                                   input logic [N_CDB*ROB_TAG_W-1:0] ct,
                                   input logic [N_CDB*XLEN-1:0] cv,
                                   input logic [ROB_TAG_W-1:0] lt,
                                   input logic [XLEN-1:0] lv);
      opnd_t r;
      logic  hit;
      r   = o;
      hit = 1'b0;
      if (o.q != '0) begin
         for (int c = 0; c < N_CDB; c++) begin
            if (!hit && ct[c*ROB_TAG_W +: ROB_TAG_W] == o.q) begin
               r.q = '0;
               r.v = cv[c*XLEN +: XLEN];
               hit = 1'b1;
            end
         end
         if (!hit && lt == o.q) begin
            r.q = '0;
            r.v = lv;
         end
      end
      return r;
   endfunction

   // Load data extension; raw data arrives low-aligned.
   function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] d,
                                              input logic [1:0] sz, input logic sg);
      case (sz)
         2'd0:    extend = {{(XLEN-8){sg & d[7]}}, d[7:0]};
         2'd1:    extend = {{(XLEN-16){sg & d[15]}}, d[15:0]};
         default: extend = d;
      endcase
   endfunction

   assign w_full = (r_count == CW'(DEPTH));

`ifdef LSB_MISALIGN_EN
   // Alignment check for the head entry.
   always_comb begin
      case (r_ent[r_head].size)
         2'd0:    w_mis = 1'b0;
         2'd1:    w_mis = r_ent[r_head].addr[0];
         default: w_mis = |r_ent[r_head].addr[1:0];
      endcase
   end
`else
   assign w_mis = 1'b0;
`endif

   // Next-state, entry update and registered-output computation.
   always_comb begin
      w_state     = r_state;
      w_ent       = r_ent;
      w_head      = r_head;
      w_tail      = r_tail;
      w_count     = r_count;
      w_mem_ce    = r_mem_ce;
      w_mem_we    = r_mem_we;
      w_mem_size  = r_mem_size;
      w_mem_addr  = r_mem_addr;
      w_mem_wdata = r_mem_wdata;
      w_cdb_tag   = '0;
      w_cdb_value = r_cdb_value;
      w_cdb_addr  = r_cdb_addr;
      w_cdb_exc   = 1'b0;
      w_pop       = 1'b0;
      w_push      = 1'b0;

      // operand snoop and address generation, all entries in parallel
      for (int i = 0; i < DEPTH; i++) begin
         if (r_ent[PW'(i)].valid) begin
            w_ent[PW'(i)].op1 = snoop(r_ent[PW'(i)].op1, in_cdb_tag, in_cdb_value,
                                      r_cdb_tag, r_cdb_value);
            w_ent[PW'(i)].op2 = snoop(r_ent[PW'(i)].op2, in_cdb_tag, in_cdb_value,
                                      r_cdb_tag, r_cdb_value);
            if (r_ent[PW'(i)].op1.q == '0 && !r_ent[PW'(i)].addr_ok) begin
               w_ent[PW'(i)].addr    = r_ent[PW'(i)].op1.v + r_ent[PW'(i)].imm;
               w_ent[PW'(i)].addr_ok = 1'b1;
            end
         end
      end

      // head-entry memory FSM
      case (r_state)
         S_IDLE: begin
            if (r_ent[r_head].valid && r_ent[r_head].addr_ok) begin
               if (!r_ent[r_head].is_store) begin
                  if (w_mis) begin
                     w_cdb_tag   = r_ent[r_head].tag;
                     w_cdb_value = '0;
                     w_cdb_exc   = 1'b1;
                     w_pop       = 1'b1;
                  end else begin
                     w_mem_ce   = 1'b1;
                     w_mem_we   = 1'b0;
                     w_mem_size = r_ent[r_head].size;
                     w_mem_addr = r_ent[r_head].addr;
                     w_state    = S_LOAD_WAIT;
                  end
               end else if (!r_ent[r_head].reported) begin
                  if (r_ent[r_head].op2.q == '0) begin
                     w_cdb_tag                = r_ent[r_head].tag;
                     w_cdb_value              = r_ent[r_head].op2.v;
                     w_cdb_addr               = r_ent[r_head].addr;
                     w_cdb_exc                = w_mis;
                     w_ent[r_head].reported   = 1'b1;
                  end
               end else if (in_commit_valid && in_commit_tag == r_ent[r_head].tag) begin
                  if (w_mis) begin
                     w_pop = 1'b1;
                  end else begin
                     w_mem_ce    = 1'b1;
                     w_mem_we    = 1'b1;
                     w_mem_size  = r_ent[r_head].size;
                     w_mem_addr  = r_ent[r_head].addr;
                     w_mem_wdata = r_ent[r_head].op2.v;
                     w_state     = S_STORE_WAIT;
                  end
               end
            end
         end
         S_LOAD_WAIT: begin
            if (in_mem_done) begin
               w_mem_ce    = 1'b0;
               w_cdb_tag   = r_ent[r_head].tag;
               w_cdb_value = extend(in_mem_data, r_ent[r_head].size, r_ent[r_head].sgn);
               w_pop       = 1'b1;
               w_state     = S_IDLE;
            end
         end
         S_STORE_WAIT: begin
            if (in_mem_done) begin
               w_mem_ce = 1'b0;
               w_mem_we = 1'b0;
               w_pop    = 1'b1;
               w_state  = S_IDLE;
            end
         end
         default: w_state = S_IDLE;
      endcase

      if (w_pop) begin
         w_ent[r_head].valid = 1'b0;
         w_head              = r_head + PW'(1);
      end

      // a pop frees the slot, so a full buffer may still accept in that cycle
      w_push = in_disp_valid && (!w_full || w_pop);
      if (w_push) begin
         w_ent[r_tail].valid    = 1'b1;
         w_ent[r_tail].is_store = in_disp_is_store;
         w_ent[r_tail].size     = in_disp_size;
         w_ent[r_tail].sgn      = in_disp_signed;
         w_ent[r_tail].addr_ok  = 1'b0;
         w_ent[r_tail].reported = 1'b0;
         w_ent[r_tail].tag      = in_disp_rob_tag;
         w_ent[r_tail].op1      = snoop({in_disp_q1, in_disp_v1}, in_cdb_tag, in_cdb_value,
                                        r_cdb_tag, r_cdb_value);
         w_ent[r_tail].op2      = snoop({in_disp_q2, in_disp_v2}, in_cdb_tag, in_cdb_value,
                                        r_cdb_tag, r_cdb_value);
         w_ent[r_tail].imm      = in_disp_imm;
         w_ent[r_tail].addr     = '0;
         w_tail                 = r_tail + PW'(1);
      end
      w_count = r_count + CW'(w_push) - CW'(w_pop);

      // flush: keep only an in-flight committed store; late load data is ignored
      if (in_flush) begin
         w_cdb_tag = '0;
         w_cdb_exc = 1'b0;
         for (int i = 0; i < DEPTH; i++) w_ent[PW'(i)].valid = 1'b0;
         if (r_state == S_STORE_WAIT && !in_mem_done) begin
            w_ent[r_head] = r_ent[r_head];
            w_head        = r_head;
            w_tail        = r_head + PW'(1);
            w_count       = CW'(1);
            w_state       = S_STORE_WAIT;
            w_mem_ce      = r_mem_ce;
            w_mem_we      = r_mem_we;
         end else begin
            w_tail   = w_head;
            w_count  = '0;
            w_state  = S_IDLE;
            w_mem_ce = 1'b0;
            w_mem_we = 1'b0;
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst)     r_state <= S_IDLE;
      else if (rdy) r_state <= w_state;
   end

   // queue and output registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) r_ent[PW'(i)] <= '0;
         r_head      <= '0;
         r_tail      <= '0;
         r_count     <= '0;
         r_mem_ce    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_size  <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_cdb_tag   <= '0;
         r_cdb_value <= '0;
         r_cdb_addr  <= '0;
         r_cdb_exc   <= 1'b0;
      end else if (rdy) begin
         r_ent       <= w_ent;
         r_head      <= w_head;
         r_tail      <= w_tail;
         r_count     <= w_count;
         r_mem_ce    <= w_mem_ce;
         r_mem_we    <= w_mem_we;
         r_mem_size  <= w_mem_size;
         r_mem_addr  <= w_mem_addr;
         r_mem_wdata <= w_mem_wdata;
         r_cdb_tag   <= w_cdb_tag;
         r_cdb_value <= w_cdb_value;
         r_cdb_addr  <= w_cdb_addr;
         r_cdb_exc   <= w_cdb_exc;
      end
   end

   assign out_full      = w_full;
   assign out_count     = r_count;
   assign out_mem_ce    = r_mem_ce;
   assign out_mem_we    = r_mem_we;
   assign out_mem_size  = r_mem_size;
   assign out_mem_addr  = r_mem_addr;
   assign out_mem_wdata = r_mem_wdata;
   assign out_cdb_tag   = r_cdb_tag;
   assign out_cdb_value = r_cdb_value;
   assign out_cdb_addr  = r_cdb_addr;
   assign out_cdb_exc   = r_cdb_exc;
endmodule
